// File: rtl/weight_buffer_loader_pkg.sv
// Shared geometry and FSM encoding for the weight buffer writer.
package weight_buffer_loader_pkg;
    localparam int LINE_W     = 4096;
    localparam int BEAT_W     = 512;
    localparam int ADDR_W     = 8;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } wbl_state_t;
endpackage

// File: rtl/weight_buffer_loader_line_packer.sv
// Assembles BEAT_W slices into one LINE_W line; beat 0 occupies the LSBs.
module line_packer
    import weight_buffer_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  slot_we,
    input  logic [BEAT_CNT_W-1:0] slot_idx,
    input  logic [BEAT_W-1:0]     slot_data,
    output logic [LINE_W-1:0]     line_next
);
    logic [BEATS-1:0][BEAT_W-1:0] slots;
    logic [BEATS-1:0][BEAT_W-1:0] merged;

    always_ff @(posedge clk) begin
        if (slot_we) begin
            slots[slot_idx] <= slot_data;
        end
    end

    // The beat being written this cycle is merged in so the last beat can
    // complete the line on the same edge it is accepted.
    always_comb begin
        merged = slots;
        if (slot_we) begin
            merged[slot_idx] = slot_data;
        end
        line_next = merged;
    end
endmodule

// File: rtl/weight_buffer_loader.sv
// Packs a narrow weight stream into full lines and writes them to consecutive buffer addresses.
module weight_buffer_loader
    import weight_buffer_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W:0]   cfg_num_lines,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    output logic              wbuf_wr_en,
    output logic [ADDR_W-1:0] wbuf_wr_addr,
    output logic [LINE_W-1:0] wbuf_wr_data,
    output logic              busy,
    output logic              done
);
    wbl_state_t            state;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [ADDR_W:0]       line_cnt;
    logic [ADDR_W:0]       num_lines;
    logic [ADDR_W-1:0]     base_addr;
    logic                  beat_fire;
    logic                  last_beat;
    logic [LINE_W-1:0]     line_next;

    assign in_ready  = (state == S_COLLECT);
    assign beat_fire = in_valid && in_ready;
    assign last_beat = (beat_cnt == BEAT_CNT_W'(BEATS - 1));

    line_packer u_line_packer (
        .clk       (clk),
        .slot_we   (beat_fire),
        .slot_idx  (beat_cnt),
        .slot_data (in_data),
        .line_next (line_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            line_cnt     <= '0;
            num_lines    <= '0;
            base_addr    <= '0;
            wbuf_wr_en   <= 1'b0;
            wbuf_wr_addr <= '0;
            wbuf_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        base_addr <= cfg_base_addr;
                        num_lines <= cfg_num_lines;
                        beat_cnt  <= '0;
                        line_cnt  <= '0;
                        busy      <= 1'b1;
                        if (cfg_num_lines == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            beat_cnt     <= '0;
                            state        <= S_WRITE;
                            wbuf_wr_en   <= 1'b1;
                            wbuf_wr_addr <= base_addr + line_cnt[ADDR_W-1:0];
                            wbuf_wr_data <= line_next;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    wbuf_wr_en <= 1'b0;
                    line_cnt   <= line_cnt + (ADDR_W+1)'(1);
                    if (line_cnt == num_lines - (ADDR_W+1)'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_buffer_loader.sv
// Scoreboard bench for weight_buffer_loader: directed jobs, monitor checks every buffer write.
module tb_weight_buffer_loader;
    import weight_buffer_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [ADDR_W:0]   cfg_num_lines = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data = '0;
    logic              wbuf_wr_en;
    logic [ADDR_W-1:0] wbuf_wr_addr;
    logic [LINE_W-1:0] wbuf_wr_data;
    logic              busy;
    logic              done;

    weight_buffer_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_lines (cfg_num_lines),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .wbuf_wr_en    (wbuf_wr_en),
        .wbuf_wr_addr  (wbuf_wr_addr),
        .wbuf_wr_data  (wbuf_wr_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int ready_hi_cnt = 0;
    int last_wr_cyc = 0;
    logic [LINE_W-1:0] last_wr_data = '0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [LINE_W-1:0] exp_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] beat_val(input logic [7:0] seed, input int k);
        logic [7:0] b;
        b = seed + 8'(k);
        return {64{b}};
    endfunction

    function automatic logic [LINE_W-1:0] make_line(input logic [7:0] seed);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = beat_val(seed, k);
        return l;
    endfunction

    task automatic expect_write(input logic [ADDR_W-1:0] addr, input logic [7:0] seed);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(make_line(seed));
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready) ready_hi_cnt++;
            if (done) done_cnt++;
            if (wbuf_wr_en) begin
                wr_cnt++;
                last_wr_cyc  = cyc;
                last_wr_data = wbuf_wr_data;
                chk("ready_low_in_write", 64'(in_ready), 64'd0);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h with nothing expected", wbuf_wr_addr);
                end else begin
                    logic [ADDR_W-1:0] ea;
                    logic [LINE_W-1:0] ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("wr_addr", 64'(wbuf_wr_addr), 64'(ea));
                    checks++;
                    if (wbuf_wr_data !== ed) begin
                        errors++;
                        $display("FAIL wr_data @%0h: got lo %0h hi %0h expected lo %0h hi %0h",
                                 wbuf_wr_addr, wbuf_wr_data[63:0], wbuf_wr_data[LINE_W-1 -: 64],
                                 ed[63:0], ed[LINE_W-1 -: 64]);
                    end
                end
            end
        end
    end

    task automatic start_job(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] n);
        cfg_base_addr = base;
        cfg_num_lines = n;
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start     = 1'b0;
        start_cyc     = cyc;
    endtask

    task automatic drive_beat(input logic [BEAT_W-1:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready %0b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // gaps holds a 2-bit idle-cycle count per beat.
    task automatic send_beats(input logic [7:0] seed, input logic [15:0] gaps, input int first, input int last);
        for (int k = first; k < last; k++) begin
            for (int g = 0; g < int'(gaps[2*k +: 2]); g++) begin
                in_valid = 1'b0;
                in_data  = '1;
                @(negedge clk);
            end
            drive_beat(beat_val(seed, k));
        end
    endtask

    task automatic wait_done(output int at_cyc);
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 64'(done), 64'd1);
        at_cyc = cyc;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0, r0, dc;

        repeat (3) @(negedge clk);
        chk("rst_wr_en", 64'(wbuf_wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wbuf_wr_addr), 64'd0);
        chk("rst_wr_data_zero", 64'(|wbuf_wr_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single line at 0x10, continuous stream
        w0 = wr_cnt; d0 = done_cnt;
        expect_write(8'h10, 8'h00);
        start_job(8'h10, 9'd1);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        send_beats(8'h00, 16'h0000, 0, BEATS);
        wait_done(dc);
        chk("t1_wr_latency", 64'(last_wr_cyc - start_cyc), 64'd8);
        chk("t1_done_latency", 64'(dc - start_cyc), 64'd9);
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_wr_count", 64'(wr_cnt - w0), 64'd1);
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_beat0_zero", 64'(last_wr_data[511:0] == '0), 64'd1);
        chk("t1_beat7_sevens", 64'(last_wr_data[4095:3584] == {64{8'h07}}), 64'd1);

        // Test 2: four lines wrapping past the top of the buffer
        w0 = wr_cnt; d0 = done_cnt;
        expect_write(8'hFE, 8'h20);
        expect_write(8'hFF, 8'h28);
        expect_write(8'h00, 8'h30);
        expect_write(8'h01, 8'h38);
        start_job(8'hFE, 9'd4);
        for (int i = 0; i < 4; i++) send_beats(8'h20 + 8'(i*8), 16'h0000, 0, BEATS);
        wait_done(dc);
        chk("t2_wr_count", 64'(wr_cnt - w0), 64'd4);
        chk("t2_done_count", 64'(done_cnt - d0), 64'd1);

        // Test 3: two lines with idle gaps between beats
        w0 = wr_cnt;
        expect_write(8'h40, 8'h80);
        expect_write(8'h41, 8'h88);
        start_job(8'h40, 9'd2);
        send_beats(8'h80, 16'hB26D, 0, BEATS);
        send_beats(8'h88, 16'h49E1, 0, BEATS);
        wait_done(dc);
        chk("t3_wr_count", 64'(wr_cnt - w0), 64'd2);

        // Test 4: zero-line job
        w0 = wr_cnt; d0 = done_cnt; r0 = ready_hi_cnt;
        start_job(8'h33, 9'd0);
        chk("t4_done_next_cycle", 64'(done), 64'd1);
        chk("t4_busy_during_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t4_done_one_cycle", 64'(done), 64'd0);
        chk("t4_busy_low", 64'(busy), 64'd0);
        chk("t4_no_write", 64'(wr_cnt - w0), 64'd0);
        chk("t4_ready_never_high", 64'(ready_hi_cnt - r0), 64'd0);
        chk("t4_done_count", 64'(done_cnt - d0), 64'd1);

        // Test 5: cfg_start mid-job is ignored
        w0 = wr_cnt; d0 = done_cnt;
        expect_write(8'h30, 8'h50);
        expect_write(8'h31, 8'h58);
        start_job(8'h30, 9'd2);
        send_beats(8'h50, 16'h0000, 0, 3);
        cfg_start = 1'b1; cfg_base_addr = 8'h80; cfg_num_lines = 9'd5;
        drive_beat(beat_val(8'h50, 3));
        cfg_start = 1'b0;
        send_beats(8'h50, 16'h0000, 4, BEATS);
        send_beats(8'h58, 16'h0000, 0, BEATS);
        wait_done(dc);
        chk("t5_wr_count", 64'(wr_cnt - w0), 64'd2);
        chk("t5_done_count", 64'(done_cnt - d0), 64'd1);

        // Test 6: reset partway through the second line, then a fresh job
        w0 = wr_cnt;
        expect_write(8'h50, 8'h60);
        start_job(8'h50, 9'd3);
        send_beats(8'h60, 16'h0000, 0, BEATS);
        send_beats(8'h68, 16'h0000, 0, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 64'(wbuf_wr_en), 64'd0);
        chk("t6_rst_wr_addr", 64'(wbuf_wr_addr), 64'd0);
        chk("t6_rst_wr_data_zero", 64'(|wbuf_wr_data), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_write(8'h20, 8'hA0);
        start_job(8'h20, 9'd1);
        send_beats(8'hA0, 16'h0000, 0, BEATS);
        wait_done(dc);
        chk("t6_wr_count", 64'(wr_cnt - w0), 64'd2);
        chk("t6_busy_low", 64'(busy), 64'd0);

        chk("scoreboard_drained", 64'(exp_addr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
